rr_arb4: RTL and testbench
==========================

Name: rr_arb4

Overview:
- Four-channel round-robin arbiter with a single registered output slot.
- Collects N-bit words from four valid/ready producers and grants one per cycle, rotating priority.
- Steers the granted word through a mux4 onto a registered valid/ready output.
- Sits directly upstream of the consumer of mux4-selected data and generates the 2-bit select that feeds the mux4 stage.

Parameters:
N, 5, data width of every input channel and of out_data.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  4  bit i high: channel i presents a word.
in0  input  N  channel 0 data.
in1  input  N  channel 1 data.
in2  input  N  channel 2 data.
in3  input  N  channel 3 data.
in_ready  output  4  one-hot or zero; bit i high: channel i word accepted this cycle.
out_valid  output  1  output slot holds a word.
out_ready  input  1  downstream accepts the word this cycle.
out_data  output  N  registered granted word.
out_src  output  2  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer last=3, so channel 0 has highest priority first.
  - in_ready=0 during the reset cycle.
  - A held word is discarded on reset mid-operation. No transfer on either side counts during the reset cycle.
- Load enable: load_en = !out_valid | out_ready. The slot is free, or is being drained this same cycle.
- Grant search (combinational):
  - Scan channels in order last+1, last+2, last+3, last (mod 4). The first with in_valid high wins, giving gnt[1:0].
  - No in_valid high: no grant.
- in_ready[gnt] = load_en & any(in_valid). All other bits are 0.
  - in_ready depends combinationally on in_valid and out_ready. There is no combinational path from in0..in3.
- Mux: the granted word is in[gnt], through the mux4 structure with select=gnt.
- Input transfer on channel i: in_valid[i] & in_ready[i] at the clock edge. Effects on that edge:
  - out_data <= in[gnt], out_src <= gnt, out_valid <= 1, last <= gnt.
- Output transfer: out_valid & out_ready at the clock edge.
  - If there is no simultaneous input transfer, out_valid <= 0. out_data and out_src hold their values.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old. This gives full throughput of one word per cycle.
- Backpressure (out_valid & !out_ready): out_data and out_src are stable, in_ready=0, last is unchanged.
- The pointer advances only on an input transfer. Idle cycles and stalled cycles do not rotate priority.
- Fairness: with all four channels continuously valid and out_ready=1, grants cycle 0,1,2,3,0,... Any continuously valid channel waits at most 3 transfers.
- Producers may drop in_valid without a transfer. The arbiter does not latch requests.
- Latency: one cycle from input transfer to out_valid.
- State machine (2 states, encoded by out_valid):
  - EMPTY -> FULL on input transfer.
  - FULL -> EMPTY on output transfer without an input transfer.
  - FULL -> FULL on stall, or on drain plus load.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> out_valid=0, out_data=0, out_src=0, in_ready=0000 throughout.
- Single channel: in_valid=0100, in2=5'h15, out_ready=1 -> in_ready=0100 that cycle. Next cycle out_valid=1, out_data=5'h15, out_src=2.
- Full contention: in_valid=1111, in_i=i+8, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3. out_data 8,9,10,11,... with out_valid continuously 1.
- Backpressure: slot holds in1=5'h0A (out_src=1), out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000 and out_data=5'h0A stable. On release, the next grant is channel 2.
- Skip and sparse: last=0, in_valid=1001 -> channel 3 granted, then channel 0. in_valid=0000 for one cycle, then 1111 -> channel 1 granted (pointer did not move while idle).
- Reset mid-hold: out_valid=1, out_ready=0, rst=1 one cycle -> next cycle out_valid=0. With in_valid=1111, the first grant after reset is channel 0.

Source files
------------

// File: rtl/rr_arb4_if.sv
// Valid/ready bundle between four producers, the rr_arb4 arbiter and its
// single downstream consumer. The arbiter takes the slave side.
interface rr_arb4_if #(
  parameter int N = 5
);
  logic [3:0]   in_valid;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] in3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   out_src;

  modport master (
    output in_valid, in0, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in0, in1, in2, in3, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter feeding one registered output slot.
// The granted word is steered through a 4:1 mux selected by the grant index.
//
// state | meaning
// EMPTY | output slot holds no word (out_valid=0)
// FULL  | output slot holds a word (out_valid=1)
module rr_arb4 #(
  parameter int N = 5
) (
  input logic   clk,
  input logic   rst,
  rr_arb4_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state;
  logic [1:0]   last;
  logic [N-1:0] data_q;
  logic [1:0]   src_q;

  logic [1:0]   gnt;
  logic [1:0]   cand;
  logic         any_req;
  logic         load_en;
  logic         xfer_in;
  logic [N-1:0] mux_out;

  // Rotating-priority scan: last+1 first, last itself last.
  always_comb begin
    gnt     = 2'd0;
    any_req = 1'b0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!any_req && bus.in_valid[cand]) begin
        gnt     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Mux4 stage selected by the grant; data never reaches in_ready.
  always_comb begin
    case (gnt)
      2'd0:    mux_out = bus.in0;
      2'd1:    mux_out = bus.in1;
      2'd2:    mux_out = bus.in2;
      default: mux_out = bus.in3;
    endcase
  end

  // Slot can accept when empty or draining this cycle; nothing accepted in reset.
  always_comb begin
    load_en      = (state == EMPTY) || bus.out_ready;
    bus.in_ready = 4'b0000;
    if (load_en && any_req && !rst) begin
      bus.in_ready[gnt] = 1'b1;
    end
    xfer_in = |(bus.in_valid & bus.in_ready);
  end

  // Slot FSM, registered word/source and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      src_q  <= 2'd0;
      last   <= 2'd3;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            state  <= FULL;
            data_q <= mux_out;
            src_q  <= gnt;
            last   <= gnt;
          end
        end
        FULL: begin
          if (xfer_in) begin
            data_q <= mux_out;
            src_q  <= gnt;
            last   <= gnt;
          end else if (bus.out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios with literal expectations, then
// random traffic, all checked each cycle against a behavioural model.
module tb_rr_arb4;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]   iv;
  logic         ordy;
  logic [N-1:0] din [4];

  int vectors = 0;
  int miscompares = 0;

  rr_arb4_if #(.N(N)) bus ();

  assign bus.in_valid  = iv;
  assign bus.in0       = din[0];
  assign bus.in1       = din[1];
  assign bus.in2       = din[2];
  assign bus.in3       = din[3];
  assign bus.out_ready = ordy;

  rr_arb4 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: slot contents plus index of the last granted channel.
  bit        m_known = 1'b0;
  bit        m_valid;
  int        m_data;
  int        m_src;
  int        m_last;

  always @(negedge clk) begin
    int best;
    int best_dist;
    int exp_rdy;
    bit can_load;
    best = -1;
    best_dist = 4;
    exp_rdy = 0;
    if (!rst) begin
      can_load = !m_valid || ordy;
      for (int i = 0; i < 4; i++) begin
        if (iv[i] && ((i - m_last + 3) % 4) < best_dist) begin
          best_dist = (i - m_last + 3) % 4;
          best = i;
        end
      end
      if (can_load && best >= 0) exp_rdy = 1 << best;
    end
    chk("in_ready", int'(bus.in_ready), exp_rdy);
    if (m_known) begin
      chk("out_valid", int'(bus.out_valid), int'(m_valid));
      chk("out_data", int'(bus.out_data), m_data);
      chk("out_src", int'(bus.out_src), m_src);
    end
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_data  = 0;
      m_src   = 0;
      m_last  = 3;
    end else if (exp_rdy != 0) begin
      m_valid = 1'b1;
      m_data  = int'(din[best]);
      m_src   = best;
      m_last  = best;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    iv   = 4'b0000;
    ordy = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;

    // Reset then idle.
    next();
    next();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_src", int'(bus.out_src), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);

    // Single channel.
    rst = 1'b0;
    iv = 4'b0100; din[2] = 5'h15; ordy = 1'b1;
    #1 chk("single_in_ready", int'(bus.in_ready), 4'b0100);
    next();
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_data", int'(bus.out_data), 5'h15);
    chk("single_src", int'(bus.out_src), 2);

    // Full contention from a fresh pointer.
    iv = 4'b0000; rst = 1'b1;
    next();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = N'(i + 8);
    iv = 4'b1111; ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next();
      chk("rr_valid", int'(bus.out_valid), 1);
      chk("rr_src", int'(bus.out_src), k % 4);
      chk("rr_data", int'(bus.out_data), 8 + k % 4);
    end

    // Backpressure holding channel 1.
    iv = 4'b0010; din[1] = 5'h0A;
    next();
    chk("bp_load_src", int'(bus.out_src), 1);
    iv = 4'b1111; ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", int'(bus.in_ready), 0);
      next();
      chk("bp_data", int'(bus.out_data), 5'h0A);
      chk("bp_src", int'(bus.out_src), 1);
    end
    ordy = 1'b1;
    #1 chk("bp_release_rdy", int'(bus.in_ready), 4'b0100);
    next();
    chk("bp_release_src", int'(bus.out_src), 2);

    // Skip and sparse, starting from last=0.
    iv = 4'b0001;
    next();
    iv = 4'b1001;
    #1 chk("skip_rdy3", int'(bus.in_ready), 4'b1000);
    next();
    chk("skip_src3", int'(bus.out_src), 3);
    chk("skip_rdy0", int'(bus.in_ready), 4'b0001);
    next();
    chk("skip_src0", int'(bus.out_src), 0);
    iv = 4'b0000;
    next();
    iv = 4'b1111;
    #1 chk("sparse_rdy1", int'(bus.in_ready), 4'b0010);
    next();
    chk("sparse_src1", int'(bus.out_src), 1);

    // Reset while holding a stalled word.
    ordy = 1'b0;
    next();
    rst = 1'b1;
    #1 chk("midrst_rdy", int'(bus.in_ready), 0);
    next();
    chk("midrst_valid", int'(bus.out_valid), 0);
    rst = 1'b0; ordy = 1'b1;
    #1 chk("midrst_first_rdy", int'(bus.in_ready), 4'b0001);
    next();
    chk("midrst_first_src", int'(bus.out_src), 0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      iv   = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) din[i] = N'($urandom);
      next();
    end
    rst = 1'b0;
    next();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
